// File: rtl/ring_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_scanner_pkg
//  Description : Shared mode encodings and the period helper for the
//                ring_scanner multi-mode shift counter.
//  Contents    : MODE_RING / MODE_JOHNSON / MODE_HOLD / MODE_RSVD,
//                mode_period() - steps per period for a mode and size.
//  Revision    : 1.0  initial release
// ============================================================================
package ring_scanner_pkg;

    localparam logic [1:0] MODE_RING    = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    // A Johnson counter visits twice as many states as a ring counter of
    // the same width. Hold has no real period; size is returned so pos
    // arithmetic stays well defined.
    function automatic int unsigned mode_period(input logic [1:0] mode,
                                                input int unsigned size);
        return (mode == MODE_JOHNSON) ? (2 * size) : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_scanner_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides enabled clock cycles down to one step tick every
//                PRESCALE enabled cycles. Count freezes while en is low.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                en_i       - advance the count this cycle
//                clr_i      - synchronous clear (load / mode change)
//                tick_o     - combinational: en_i while count is terminal
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    // One bit is kept even for PRESCALE=1; it then never leaves 0 and the
    // tick collapses to en_i.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] pcnt_d;
    logic          w_tick;

    assign w_tick = en_i && (pcnt_q == c_LAST);
    assign tick_o = w_tick;

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (w_tick) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : ring_scanner
//  Description : Multi-mode shift counter for digit scanning / phase
//                sequencing: ring, Johnson or hold, either direction, with
//                prescaler, parallel load and stuck-state recovery.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                en_i        - count enable
//                dir_i       - 0 shift toward MSB, 1 shift toward LSB
//                mode_i      - 00 ring, 01 Johnson, 10 hold, 11 as ring
//                load_i      - parallel load strobe
//                load_val_i  - value written on load
//                ring_o      - counter contents
//                pos_o       - step index within the period
//                step_o      - pulse with each newly visible value
//                wrap_o      - pulse with step when pos wraps
//  Revision    : 1.0  initial release
// ============================================================================
module ring_scanner
    import ring_scanner_pkg::*;
#(
    parameter int unsigned          SIZE     = 4,
    parameter logic [SIZE-1:0]      INIT_VAL = {{(SIZE-1){1'b0}}, 1'b1},
    parameter int unsigned          PRESCALE = 1,
    localparam int unsigned         PW       = $clog2(2 * SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [SIZE-1:0]  load_val_i,
    output logic [SIZE-1:0]  ring_o,
    output logic [PW-1:0]    pos_o,
    output logic             step_o,
    output logic             wrap_o
);

    logic [SIZE-1:0] ring_q, ring_d;
    logic [PW-1:0]   pos_q,  pos_d;
    logic            step_q, step_d;
    logic            wrap_q, wrap_d;
    logic [1:0]      mode_q, mode_d;

    logic [1:0]      w_mode_eff;
    logic            w_mode_chg;
    logic            w_tick;
    logic            w_johnson;
    logic            w_stuck;
    logic [PW-1:0]   w_last;
    logic [SIZE-1:0] w_shift;

    // Reserved encoding is folded into ring before storing and comparing,
    // so toggling between 00 and 11 never counts as a mode change.
    assign w_mode_eff = (mode_i == MODE_RSVD) ? MODE_RING : mode_i;
    assign w_mode_chg = (w_mode_eff != mode_q);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .clr_i  (load_i || w_mode_chg),
        .tick_o (w_tick)
    );

    assign w_johnson = (mode_q == MODE_JOHNSON);
    assign w_stuck   = (~|ring_q) || (&ring_q);
    assign w_last    = PW'(mode_period(mode_q, SIZE) - 1);

    // Johnson differs from ring only by inverting the bit fed back in.
    always_comb begin
        if (!dir_i) begin
            w_shift = {ring_q[SIZE-2:0], ring_q[SIZE-1] ^ w_johnson};
        end else begin
            w_shift = {ring_q[0] ^ w_johnson, ring_q[SIZE-1:1]};
        end
    end

    always_comb begin
        ring_d = ring_q;
        pos_d  = pos_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        mode_d = mode_q;
        if (load_i) begin
            ring_d = load_val_i;
            pos_d  = '0;
            mode_d = w_mode_eff;
        end else if (w_mode_chg) begin
            mode_d = w_mode_eff;
            pos_d  = '0;
            if (w_mode_eff == MODE_RING) begin
                ring_d = INIT_VAL;
            end else if (w_mode_eff == MODE_JOHNSON) begin
                ring_d = '0;
            end
        end else if (w_tick) begin
            step_d = 1'b1;
            if (mode_q == MODE_HOLD) begin
                // step still pulses so downstream timing is mode-independent
            end else if (mode_q == MODE_RING && w_stuck) begin
                ring_d = INIT_VAL;
                pos_d  = '0;
            end else begin
                ring_d = w_shift;
                if (!dir_i) begin
                    if (pos_q == w_last) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d  = w_last;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= INIT_VAL;
            pos_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            mode_q <= MODE_RING;
        end else begin
            ring_q <= ring_d;
            pos_q  <= pos_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
        end
    end

    assign ring_o = ring_q;
    assign pos_o  = pos_q;
    assign step_o = step_q;
    assign wrap_o = wrap_q;

endmodule
`default_nettype wire
